// File: rtl/sync_ctrl_pkg.sv
// Shared definitions for the sync bus scheduler: FSM state encoding and
// helper functions used to size the counter and index registers.
package sync_ctrl_pkg;

  // Transfer sequence states; the encoding is fixed so it can be probed
  // consistently from other blocks and from waveforms.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ASSERT = 2'd2,
    HOLD   = 2'd3
  } sync_state_t;

  // Larger of two integers, used to size the shared enable/hold counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold the values 0 .. max_count-1 (at least one bit).
  function automatic int cnt_width(input int max_count);
    return (max_count <= 1) ? 1 : $clog2(max_count);
  endfunction

  // Bits needed to hold a requester index 0 .. num_req-1 (at least one bit).
  function automatic int idx_width(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/sync_rr_arbiter.sv
// Combinational round-robin selector. The search starts at the requester
// just after last_owner and wraps, so the previous owner has lowest priority.
module sync_rr_arbiter
  import sync_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] winner_onehot,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters in rotated priority order and take the first active one.
  always_comb begin
    winner_onehot = '0;
    winner_idx    = '0;
    valid         = 1'b0;
    cand          = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid               = 1'b1;
        winner_onehot[cand] = 1'b1;
        winner_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/sync_bus_scheduler.sv
// Source-domain scheduler for a shared CDC data channel. A round-robin
// winner's word is latched onto unsyn_bus, then bus_enable is raised for
// EN_CYCLES and the word is held for HOLD_CYCLES more before the next
// transfer may start, giving the destination synchronizer a clean window.
// NUM_REQ must be at least 2; EN_CYCLES and HOLD_CYCLES at least 1.
module sync_bus_scheduler
  import sync_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_REQ     = 4,
  parameter int EN_CYCLES   = 3,
  parameter int HOLD_CYCLES = 6
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [BUS_WIDTH-1:0]         unsyn_bus,
  output logic                         bus_enable,
  output logic                         busy
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = cnt_width(max_int(EN_CYCLES, HOLD_CYCLES));

  // Counter reload values: the counter runs down to zero, so a phase of
  // N cycles is loaded with N-1.
  localparam logic [CNT_W-1:0] EN_LOAD   = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  sync_state_t state, state_next;

  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [IDX_W-1:0]     owner, owner_next;
  logic [IDX_W-1:0]     last_owner, last_owner_next;
  logic [BUS_WIDTH-1:0] bus_next;
  logic                 en_next;
  logic [NUM_REQ-1:0]   grant_next;
  logic [NUM_REQ-1:0]   done_next;

  logic [NUM_REQ-1:0]   arb_onehot;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;

  logic [BUS_WIDTH-1:0] req_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[i*BUS_WIDTH +: BUS_WIDTH];
  end

  sync_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arbiter (
    .req           (req),
    .last_owner    (last_owner),
    .winner_onehot (arb_onehot),
    .winner_idx    (arb_idx),
    .valid         (arb_valid)
  );

  // busy simply reflects that a transfer sequence is in progress.
  assign busy = (state != IDLE);

  // Next-state and next-output decode for the transfer sequence.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    owner_next      = owner;
    last_owner_next = last_owner;
    bus_next        = unsyn_bus;
    en_next         = bus_enable;
    grant_next      = '0;
    done_next       = '0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          bus_next   = req_word[arb_idx];
          owner_next = arb_idx;
          grant_next = arb_onehot;
          state_next = LOAD;
        end
      end
      LOAD: begin
        en_next    = 1'b1;
        cnt_next   = EN_LOAD;
        state_next = ASSERT;
      end
      ASSERT: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          en_next    = 1'b0;
          cnt_next   = HOLD_LOAD;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          done_next[owner] = 1'b1;
          last_owner_next  = owner;
          state_next       = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counter, ownership and registered channel outputs; last_owner resets to
  // the top index so requester 0 has first priority after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      unsyn_bus  <= '0;
      bus_enable <= 1'b0;
      grant      <= '0;
      done       <= '0;
    end else begin
      cnt        <= cnt_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      unsyn_bus  <= bus_next;
      bus_enable <= en_next;
      grant      <= grant_next;
      done       <= done_next;
    end
  end

endmodule
